// File: rtl/mat_sigmoid_arbiter_if.sv
// Bundle of requester-side and unit-side handshake buses for the mat_sigmoid arbiter.
// master = arbiter side, slave = requesters plus shared unit.
interface mat_sigmoid_arbiter_if #(
  parameter int unsigned M    = 2,
  parameter int unsigned N    = 3,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned MW = M * N * 32;
  localparam int unsigned GW = $clog2(NREQ);

  logic [NREQ*MW-1:0] req_mat;
  logic [NREQ-1:0]    req_stb;
  logic [NREQ-1:0]    req_ack;
  logic [MW-1:0]      resp_mat;
  logic [NREQ-1:0]    resp_stb;
  logic [NREQ-1:0]    resp_ack;
  logic [MW-1:0]      unit_in_mat;
  logic               unit_in_stb;
  logic               unit_in_ack;
  logic [MW-1:0]      unit_out_mat;
  logic               unit_out_stb;
  logic               unit_out_ack;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    input  req_mat, req_stb, resp_ack, unit_in_ack, unit_out_mat, unit_out_stb,
    output req_ack, resp_mat, resp_stb, unit_in_mat, unit_in_stb, unit_out_ack, grant_id, busy
  );

  modport slave (
    output req_mat, req_stb, resp_ack, unit_in_ack, unit_out_mat, unit_out_stb,
    input  req_ack, resp_mat, resp_stb, unit_in_mat, unit_in_stb, unit_out_ack, grant_id, busy
  );
endinterface

// File: rtl/mat_sigmoid_arbiter.sv
// Round-robin arbiter sharing one mat_sigmoid unit among NREQ requesters.
// A grant spans operand issue, unit compute and return from a local result buffer.
module mat_sigmoid_arbiter #(
  parameter int unsigned M    = 2,
  parameter int unsigned N    = 3,
  parameter int unsigned NREQ = 4
) (
  input logic                   clk,
  input logic                   rst,
  mat_sigmoid_arbiter_if.master bus
);
  localparam int unsigned MW = M * N * 32;
  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [MW-1:0] buf_q, buf_d;
  logic [GW-1:0] pick;
  logic          pick_valid;

  // First requester found scanning upward from rr_q, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && bus.req_stb[idx]) begin
        pick       = GW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    buf_d            = buf_q;
    bus.req_ack      = '0;
    bus.resp_stb     = '0;
    bus.unit_in_mat  = '0;
    bus.unit_in_stb  = 1'b0;
    bus.unit_out_ack = 1'b0;
    bus.resp_mat     = buf_q;
    bus.grant_id     = grant_q;
    bus.busy         = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = StIssue;
        end
      end
      StIssue: begin
        bus.unit_in_mat       = bus.req_mat[32'(grant_q)*MW +: MW];
        bus.unit_in_stb       = bus.req_stb[grant_q];
        bus.req_ack[grant_q]  = bus.unit_in_ack & bus.req_stb[grant_q];
        // Requester withdrew before the unit took the operand: release without moving rr.
        if (!bus.req_stb[grant_q]) begin
          state_d = StIdle;
        end else if (bus.unit_in_ack) begin
          state_d = StWait;
        end
      end
      StWait: begin
        bus.unit_out_ack = 1'b1;
        if (bus.unit_out_stb) begin
          buf_d   = bus.unit_out_mat;
          state_d = StReturn;
        end
      end
      StReturn: begin
        bus.resp_stb[grant_q] = 1'b1;
        if (bus.resp_ack[grant_q]) begin
          state_d = StIdle;
          rr_d    = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      buf_q   <= buf_d;
    end
  end
endmodule
